// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver capture and host read signals of the UART RX FIFO
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rx_flag;
    logic [DATA_W-1:0] Rx_Data;
    logic              parity_error;
    logic              rx_flag_clr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;
    logic              overrun_clr;

    // FIFO side
    modport slave (
        input  rx_flag, Rx_Data, parity_error, rd_en, overrun_clr,
        output rx_flag_clr, rd_data, rd_perr, empty, full, count, overrun
    );

    // receiver/host side
    modport master (
        output rx_flag, Rx_Data, parity_error, rd_en, overrun_clr,
        input  rx_flag_clr, rd_data, rd_perr, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer: captures flagged bytes into a FWFT FIFO
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            nrst,
    uart_rx_fifo_if.slave   rx_if
);
    typedef enum logic [1:0] {IDLE, CLR, WAIT_LOW} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state_q;
    logic                clr_q;
    logic [DATA_W:0]     mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                empty_q, full_q;
    logic                overrun_q, overrun_d;
    logic                capture, pop, wr;
    logic [DATA_W:0]     head;

    // Capture decision, write/pop qualification and next pointer/count/overrun values
    always_comb begin
        capture   = (state_q == IDLE) && rx_if.rx_flag;
        pop       = rx_if.rd_en && !empty_q;
        // a full FIFO still accepts the byte when the head leaves on the same edge
        wr        = capture && ((count_q < DEPTH_C) || pop);
        wr_ptr_d  = wr  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        overrun_d = overrun_q;
        if (capture && !wr) begin
            overrun_d = 1'b1;
        end else if (rx_if.overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Capture FSM: one capture per rx_flag assertion, one-cycle clear pulse, then wait for the flag to drop
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    clr_q <= 1'b0;
                    if (rx_if.rx_flag) begin
                        state_q <= CLR;
                        clr_q   <= 1'b1;
                    end
                end
                CLR: begin
                    state_q <= WAIT_LOW;
                    clr_q   <= 1'b0;
                end
                WAIT_LOW: begin
                    clr_q <= 1'b0;
                    if (!rx_if.rx_flag) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    clr_q   <= 1'b0;
                end
            endcase
        end
    end

    // Pointer, occupancy and status registers; empty/full follow the next count
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == DEPTH_C);
            overrun_q <= overrun_d;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= {rx_if.parity_error, rx_if.Rx_Data};
        end
    end

    assign head              = mem[rd_ptr_q];
    assign rx_if.rd_data     = empty_q ? '0 : head[DATA_W-1:0];
    assign rx_if.rd_perr     = !empty_q && head[DATA_W];
    assign rx_if.rx_flag_clr = clr_q;
    assign rx_if.empty       = empty_q;
    assign rx_if.full        = full_q;
    assign rx_if.count       = count_q;
    assign rx_if.overrun     = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .rx_if (bus)
    );

    logic [8:0] q[$];
    bit         ovr_m;
    bit         armed_m;
    bit         clr_m;
    int         since_m;
    bit         hold;
    int         checks;
    int         passes;
    int         pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Effect of the coming clock edge on the model, from the inputs now applied
    task automatic model_edge();
        bit cap, pp, wr;
        if (!nrst) begin
            q.delete();
            ovr_m   = 0;
            armed_m = 1;
            clr_m   = 0;
            since_m = 100;
        end else begin
            cap = armed_m && bus.rx_flag;
            pp  = bus.rd_en && (q.size() > 0);
            wr  = cap && ((q.size() < DEPTH) || pp);
            if (pp) void'(q.pop_front());
            if (wr) q.push_back({bus.parity_error, bus.Rx_Data});
            if (cap && !wr) ovr_m = 1;
            else if (bus.overrun_clr) ovr_m = 0;
            clr_m = cap;
            if (cap) begin
                armed_m = 0;
                since_m = 0;
            end else begin
                since_m++;
                if (!armed_m && since_m >= 2 && !bus.rx_flag) armed_m = 1;
            end
        end
    endtask

    task automatic compare();
        logic [8:0]  h;
        logic [17:0] exp_v, act_v;
        h = (q.size() > 0) ? q[0] : 9'h000;
        exp_v = {clr_m, h[8], h[7:0], q.size() == 0, q.size() == DEPTH, 5'(q.size()), ovr_m};
        act_v = {bus.rx_flag_clr, bus.rd_perr, bus.rd_data, bus.empty, bus.full, bus.count, bus.overrun};
        chk("cycle", 32'(act_v), 32'(exp_v));
    endtask

    // One clock: predict, advance, let the receiver honour a clear pulse, then compare
    task automatic step();
        bit prev_clr;
        prev_clr = clr_m;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (prev_clr && !hold) bus.rx_flag = 1'b0;
        compare();
    endtask

    task automatic raise(input logic [7:0] d, input logic p, input logic rd, input logic oc);
        bus.Rx_Data      = d;
        bus.parity_error = p;
        bus.rx_flag      = 1'b1;
        bus.rd_en        = rd;
        bus.overrun_clr  = oc;
        step();
        bus.rd_en       = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic finish_byte();
        int n;
        n = 0;
        while (bus.rx_flag && n < 10) begin
            step();
            n++;
        end
        chk("rx_flag_drop", 32'(bus.rx_flag), 32'd0);
        step();
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        raise(d, p, 1'b0, 1'b0);
        finish_byte();
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        hold   = 0;
        bus.rx_flag      = 1'b0;
        bus.Rx_Data      = '0;
        bus.parity_error = 1'b0;
        bus.rd_en        = 1'b0;
        bus.overrun_clr  = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_clr", 32'(bus.rx_flag_clr), 32'd0);

        // single capture
        raise(8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t1_clr", 32'(bus.rx_flag_clr), 32'd1);
        chk("t1_data", 32'(bus.rd_data), 32'hA5);
        chk("t1_perr", 32'(bus.rd_perr), 32'd0);
        chk("t1_count", 32'(bus.count), 32'd1);
        chk("t1_empty", 32'(bus.empty), 32'd0);
        finish_byte();
        pop();

        // flag held high for 10 cycles
        hold = 1;
        bus.Rx_Data = 8'h3C;
        bus.rx_flag = 1'b1;
        pulses = 0;
        repeat (10) begin
            step();
            if (bus.rx_flag_clr) pulses++;
        end
        hold = 0;
        bus.rx_flag = 1'b0;
        step();
        step();
        chk("t2_pulses", 32'(pulses), 32'd1);
        chk("t2_count", 32'(bus.count), 32'd1);
        chk("t2_data", 32'(bus.rd_data), 32'h3C);
        pop();

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        send(8'hFF, 1'b0);
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_count", 32'(bus.count), 32'd16);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("t3_empty", 32'(bus.empty), 32'd1);
        chk("t3_zero", 32'(bus.rd_data), 32'd0);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);

        // capture into a full FIFO with a simultaneous pop
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
        raise(8'h77, 1'b0, 1'b1, 1'b0);
        chk("t4_count", 32'(bus.count), 32'd16);
        chk("t4_overrun", 32'(bus.overrun), 32'd0);
        finish_byte();
        for (int i = 0; i < 15; i++) begin
            chk("t4_order", 32'(bus.rd_data), 32'(8'h41 + i));
            pop();
        end
        chk("t4_last", 32'(bus.rd_data), 32'h77);
        pop();

        // pointer wrap
        for (int i = 0; i < 10; i++) send(8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) pop();
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk("t5_order", 32'(bus.rd_data), 32'(8'h10 + i));
            pop();
        end
        chk("t5_empty", 32'(bus.empty), 32'd1);

        // pop on empty, parity bit, set-over-clear priority
        pop();
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_empty", 32'(bus.empty), 32'd1);
        send(8'h55, 1'b1);
        chk("t6_perr", 32'(bus.rd_perr), 32'd1);
        chk("t6_data", 32'(bus.rd_data), 32'h55);
        pop();
        for (int i = 0; i < 16; i++) send(8'(i * 3), 1'b0);
        raise(8'h99, 1'b0, 1'b0, 1'b1);
        chk("t6_ovr_prio", 32'(bus.overrun), 32'd1);
        finish_byte();
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        for (int i = 0; i < 16; i++) pop();

        // randomized traffic with occasional resets
        for (int c = 0; c < 1600; c++) begin
            bus.rd_en       = (c < 800) ? ($urandom % 8 == 0) : ($urandom % 2 == 0);
            bus.overrun_clr = ($urandom % 40 == 0);
            if (!bus.rx_flag && armed_m && ($urandom % 2 == 0)) begin
                bus.Rx_Data      = 8'($urandom);
                bus.parity_error = 1'($urandom);
                bus.rx_flag      = 1'b1;
            end
            nrst = !($urandom % 300 == 0);
            step();
            nrst = 1'b1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
